// File: rtl/control_unit.sv
// control_unit: multicycle Moore FSM producing the CPU datapath control word
// Ports: clk; reset (async, active-low); OPCODE/FUNCT instruction fields;
//   overflow/EQ ALU flags; md_done/div_zero mult/div status;
//   wr_en, IorD, EXCPCtrl, RegDst, DataSrc, ALUSrcA, ALUSrcB, ALUOp, PCSrc control word;
//   md_start/md_sel mult/div handshake.
// Option macro MULT_DIV_EN: enables the mult/div sequence; without it mult/div trap as bad opcode.
module control_unit #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       overflow,
  input  logic       EQ,
  input  logic       md_done,
  input  logic       div_zero,
  output logic [9:0] wr_en,
  output logic [2:0] IorD,
  output logic [1:0] EXCPCtrl,
  output logic [1:0] RegDst,
  output logic [3:0] DataSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       md_start,
  output logic       md_sel
);
  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_FWAIT, S_IR, S_DECODE,
    S_EX_ADD, S_EX_SUB, S_EX_AND, S_EX_SLT, S_EX_ADDI,
    S_WB_R, S_WB_I, S_WB_SLT, S_WB_LUI, S_WB_HI, S_WB_LO,
    S_ADDR, S_RD_WAIT, S_MDR, S_WB_MEM, S_WRITE,
    S_BRANCH, S_JUMP, S_JAL, S_JR,
    S_EXC_SAVE, S_EXC_RD, S_EXC_LD, S_EXC_JMP,
    S_MD_START, S_MD_WAIT, S_HILO
  } state_t;
  state_t r_state, w_next, w_dec;
  logic [1:0] r_exc, w_cause;
  logic [9:0] w_wr;
  logic [2:0] w_iord, w_op;
  logic [1:0] w_exc, w_rd, w_sa, w_sb, w_pcs;
  logic [3:0] w_ds;
  logic       w_ms, w_msel;
`ifdef MULT_DIV_EN
  localparam int CW = $clog2(MD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);
  logic [CW-1:0] r_cnt;
  // counts cycles spent in MD_WAIT; cleared everywhere else
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= (r_state == S_MD_WAIT) ? r_cnt + 1'b1 : '0;
`else
  logic w_unused;
  assign w_unused = ^{md_done, div_zero, MD_TIMEOUT[0]};
`endif
  // exception cause is latched on entry so it stays constant across all four exception states
  assign w_cause = (r_state == S_DECODE) ? 2'd0 : (r_state == S_MD_WAIT) ? 2'd2 : 2'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_RESET;
      r_exc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_EXC_SAVE) r_exc <= w_cause;
    end
  always_comb begin
    w_dec = S_EXC_SAVE;
    if (OPCODE == 6'h00)
      case (FUNCT)
        6'h20: w_dec = S_EX_ADD;
        6'h22: w_dec = S_EX_SUB;
        6'h24: w_dec = S_EX_AND;
        6'h2a: w_dec = S_EX_SLT;
        6'h08: w_dec = S_JR;
        6'h10: w_dec = S_WB_HI;
        6'h12: w_dec = S_WB_LO;
`ifdef MULT_DIV_EN
        6'h18, 6'h1a: w_dec = S_MD_START;
`endif
        default: w_dec = S_EXC_SAVE;
      endcase
    else
      case (OPCODE)
        6'h08: w_dec = S_EX_ADDI;
        6'h04, 6'h05: w_dec = S_BRANCH;
        6'h23, 6'h2b: w_dec = S_ADDR;
        6'h0f: w_dec = S_WB_LUI;
        6'h02: w_dec = S_JUMP;
        6'h03: w_dec = S_JAL;
        default: w_dec = S_EXC_SAVE;
      endcase
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:              w_next = S_FWAIT;
      S_FWAIT:              w_next = S_IR;
      S_IR:                 w_next = S_DECODE;
      S_DECODE:             w_next = w_dec;
      S_EX_ADD, S_EX_SUB:   w_next = overflow ? S_EXC_SAVE : S_WB_R;
      S_EX_AND:             w_next = S_WB_R;
      S_EX_SLT:             w_next = S_WB_SLT;
      S_EX_ADDI:            w_next = overflow ? S_EXC_SAVE : S_WB_I;
      S_ADDR:               w_next = (OPCODE == 6'h23) ? S_RD_WAIT : S_WRITE;
      S_RD_WAIT:            w_next = S_MDR;
      S_MDR:                w_next = S_WB_MEM;
      S_EXC_SAVE:           w_next = S_EXC_RD;
      S_EXC_RD:             w_next = S_EXC_LD;
      S_EXC_LD:             w_next = S_EXC_JMP;
`ifdef MULT_DIV_EN
      S_MD_START:           w_next = S_MD_WAIT;
      // FUNCT[1] distinguishes div (1A) from mult (18); only div can trap on a zero divisor
      S_MD_WAIT:            w_next = md_done ? ((div_zero && FUNCT[1]) ? S_EXC_SAVE : S_HILO)
                                             : (r_cnt == CNT_LAST) ? S_FETCH : S_MD_WAIT;
`endif
      default:              w_next = S_FETCH;
    endcase
  end
  always_comb begin
    w_wr = '0; w_iord = '0; w_exc = '0; w_rd = '0; w_ds = '0;
    w_sa = '0; w_sb = '0; w_op = '0; w_pcs = '0; w_ms = 1'b0; w_msel = 1'b0;
    case (r_state)
      S_RESET:    begin w_wr[3] = 1'b1; w_rd = 2'd3; w_ds = 4'd7; end
      S_FETCH:    begin w_wr[0] = 1'b1; w_sb = 2'd1; w_op = 3'b001; end
      S_IR:       w_wr[2] = 1'b1;
      S_DECODE:   begin w_wr[8:7] = 2'b11; w_wr[4] = 1'b1; w_sb = 2'd3; w_op = 3'b001; end
      S_EX_ADD:   begin w_wr[4] = 1'b1; w_sa = 2'd1; w_op = 3'b001; end
      S_EX_SUB:   begin w_wr[4] = 1'b1; w_sa = 2'd1; w_op = 3'b010; end
      S_EX_AND:   begin w_wr[4] = 1'b1; w_sa = 2'd1; w_op = 3'b011; end
      S_EX_SLT:   begin w_wr[4] = 1'b1; w_sa = 2'd1; w_op = 3'b111; end
      S_EX_ADDI:  begin w_wr[4] = 1'b1; w_sa = 2'd1; w_sb = 2'd2; w_op = 3'b001; end
      S_WB_R:     begin w_wr[3] = 1'b1; w_rd = 2'd1; end
      S_WB_I:     w_wr[3] = 1'b1;
      S_WB_SLT:   begin w_wr[3] = 1'b1; w_rd = 2'd1; w_ds = 4'd6; end
      S_WB_LUI:   begin w_wr[3] = 1'b1; w_ds = 4'd5; end
      S_WB_HI:    begin w_wr[3] = 1'b1; w_rd = 2'd1; w_ds = 4'd2; end
      S_WB_LO:    begin w_wr[3] = 1'b1; w_rd = 2'd1; w_ds = 4'd3; end
      S_ADDR:     begin w_wr[4] = 1'b1; w_sa = 2'd1; w_sb = 2'd2; w_op = 3'b001; end
      S_RD_WAIT:  w_iord = 3'd1;
      S_MDR:      begin w_iord = 3'd1; w_wr[9] = 1'b1; end
      S_WB_MEM:   begin w_wr[3] = 1'b1; w_ds = 4'd1; end
      S_WRITE:    begin w_iord = 3'd1; w_wr[1] = 1'b1; end
      // OPCODE[0] is 0 for beq and 1 for bne
      S_BRANCH:   begin w_wr[0] = EQ ^ OPCODE[0]; w_sa = 2'd1; w_op = 3'b010; w_pcs = 2'd1; end
      S_JUMP:     begin w_wr[0] = 1'b1; w_pcs = 2'd2; end
      S_JAL:      begin w_wr[0] = 1'b1; w_wr[3] = 1'b1; w_pcs = 2'd2; w_rd = 2'd2; w_ds = 4'd4; end
      S_JR:       begin w_wr[0] = 1'b1; w_sa = 2'd1; end
      S_EXC_SAVE: begin w_wr[5] = 1'b1; w_sb = 2'd1; w_op = 3'b010; w_exc = r_exc; end
      S_EXC_RD:   begin w_iord = 3'd2; w_exc = r_exc; end
      S_EXC_LD:   begin w_iord = 3'd2; w_wr[9] = 1'b1; w_exc = r_exc; end
      S_EXC_JMP:  begin w_wr[0] = 1'b1; w_pcs = 2'd3; w_exc = r_exc; end
`ifdef MULT_DIV_EN
      S_MD_START: begin w_ms = 1'b1; w_msel = FUNCT[1]; end
      S_HILO:     w_wr[6] = 1'b1;
`endif
      default:    w_wr = '0;
    endcase
  end
  // outputs are forced low while reset is asserted, so nothing leaks during an async reset
  assign wr_en    = reset ? w_wr   : '0;
  assign IorD     = reset ? w_iord : '0;
  assign EXCPCtrl = reset ? w_exc  : '0;
  assign RegDst   = reset ? w_rd   : '0;
  assign DataSrc  = reset ? w_ds   : '0;
  assign ALUSrcA  = reset ? w_sa   : '0;
  assign ALUSrcB  = reset ? w_sb   : '0;
  assign ALUOp    = reset ? w_op   : '0;
  assign PCSrc    = reset ? w_pcs  : '0;
  assign md_start = reset & w_ms;
  assign md_sel   = reset & w_msel;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit against a per-instruction sequence model
module tb_control_unit;
  typedef struct packed {
    logic [9:0] wr;
    logic [2:0] iord;
    logic [1:0] exc;
    logic [1:0] rd;
    logic [3:0] ds;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic [1:0] pcs;
    logic       ms;
    logic       msel;
  } cw_t;
  localparam cw_t Z = '0;
`ifdef MULT_DIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [5:0] OPCODE = '0, FUNCT = '0;
  logic overflow = 1'b0, EQ = 1'b0, md_done = 1'b0, div_zero = 1'b0;
  logic [9:0] wr_en;
  logic [2:0] IorD, ALUOp;
  logic [1:0] EXCPCtrl, RegDst, ALUSrcA, ALUSrcB, PCSrc;
  logic [3:0] DataSrc;
  logic md_start, md_sel;
  control_unit dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .overflow(overflow), .EQ(EQ),
    .md_done(md_done), .div_zero(div_zero), .wr_en(wr_en), .IorD(IorD), .EXCPCtrl(EXCPCtrl),
    .RegDst(RegDst), .DataSrc(DataSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .md_start(md_start), .md_sel(md_sel)
  );
  always #5 clk = ~clk;
  cw_t dut_w;
  assign dut_w = {wr_en, IorD, EXCPCtrl, RegDst, DataSrc, ALUSrcA, ALUSrcB, ALUOp, PCSrc, md_start, md_sel};
  cw_t exp_q[$];
  string tag_q[$];
  cw_t seq_w[$];
  string seq_t[$];
  int n_vec = 0, n_bad = 0;
  function automatic cw_t cw(input logic [9:0] wr, input int iord, input int exc, input int rd,
                             input int ds, input int sa, input int sb, input int op, input int pcs,
                             input int ms = 0, input int msel = 0);
    cw_t c;
    c.wr = wr; c.iord = 3'(iord); c.exc = 2'(exc); c.rd = 2'(rd); c.ds = 4'(ds);
    c.sa = 2'(sa); c.sb = 2'(sb); c.op = 3'(op); c.pcs = 2'(pcs); c.ms = 1'(ms); c.msel = 1'(msel);
    return c;
  endfunction
  function automatic void add(input cw_t w, input string t);
    seq_w.push_back(w);
    seq_t.push_back(t);
  endfunction
  function automatic void exc_seq(input int code);
    add(cw(10'h020, 0, code, 0, 0, 0, 1, 2, 0), "EXC_SAVE");
    add(cw(10'h000, 2, code, 0, 0, 0, 0, 0, 0), "EXC_RD");
    add(cw(10'h200, 2, code, 0, 0, 0, 0, 0, 0), "EXC_LD");
    add(cw(10'h001, 0, code, 0, 0, 0, 0, 0, 3), "EXC_JMP");
  endfunction
  // expected control words, cycle by cycle, for one whole instruction
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                                input logic eq, input int md_d, input logic dz);
    seq_w.delete();
    seq_t.delete();
    add(cw(10'h001, 0, 0, 0, 0, 0, 1, 1, 0), "FETCH");
    add(Z, "FETCH_WAIT");
    add(cw(10'h004, 0, 0, 0, 0, 0, 0, 0, 0), "IR");
    add(cw(10'h190, 0, 0, 0, 0, 0, 3, 1, 0), "DECODE");
    if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h2a}) begin
      add(cw(10'h010, 0, 0, 0, 0, 1, 0, fn == 6'h20 ? 1 : fn == 6'h22 ? 2 : fn == 6'h24 ? 3 : 7, 0), "EXEC");
      if (ovf && fn inside {6'h20, 6'h22}) exc_seq(1);
      else add(cw(10'h008, 0, 0, 1, fn == 6'h2a ? 6 : 0, 0, 0, 0, 0), "WB");
    end else if (op == 6'h08) begin
      add(cw(10'h010, 0, 0, 0, 0, 1, 2, 1, 0), "EXEC_ADDI");
      if (ovf) exc_seq(1);
      else add(cw(10'h008, 0, 0, 0, 0, 0, 0, 0, 0), "WB_ADDI");
    end else if (op == 6'h00 && fn == 6'h08) add(cw(10'h001, 0, 0, 0, 0, 1, 0, 0, 0), "JR");
    else if (op == 6'h00 && fn inside {6'h10, 6'h12})
      add(cw(10'h008, 0, 0, 1, fn == 6'h10 ? 2 : 3, 0, 0, 0, 0), "WB_MF");
    else if (MD && op == 6'h00 && fn inside {6'h18, 6'h1a}) begin
      add(cw(10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, fn == 6'h1a ? 1 : 0), "MD_START");
      if (md_d == 0) repeat (40) add(Z, "MD_WAIT");
      else begin
        repeat (md_d) add(Z, "MD_WAIT");
        if (dz && fn == 6'h1a) exc_seq(2);
        else add(cw(10'h040, 0, 0, 0, 0, 0, 0, 0, 0), "HILO");
      end
    end else if (op == 6'h23 || op == 6'h2b) begin
      add(cw(10'h010, 0, 0, 0, 0, 1, 2, 1, 0), "ADDR");
      if (op == 6'h23) begin
        add(cw(10'h000, 1, 0, 0, 0, 0, 0, 0, 0), "RD_WAIT");
        add(cw(10'h200, 1, 0, 0, 0, 0, 0, 0, 0), "MDR");
        add(cw(10'h008, 0, 0, 0, 1, 0, 0, 0, 0), "WB_LW");
      end else add(cw(10'h002, 1, 0, 0, 0, 0, 0, 0, 0), "WRITE");
    end else if (op == 6'h0f) add(cw(10'h008, 0, 0, 0, 5, 0, 0, 0, 0), "WB_LUI");
    else if (op == 6'h04 || op == 6'h05)
      add(cw(((op == 6'h04) == eq) ? 10'h001 : 10'h000, 0, 0, 0, 0, 1, 0, 2, 1), "BRANCH");
    else if (op == 6'h02) add(cw(10'h001, 0, 0, 0, 0, 0, 0, 0, 2), "J");
    else if (op == 6'h03) add(cw(10'h009, 0, 0, 2, 4, 0, 0, 0, 2), "JAL");
    else exc_seq(0);
  endfunction
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      cw_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (dut_w !== e) begin
        n_bad++;
        $display("FAIL %s at %0t: got %h expected %h", t, $time, dut_w, e);
      end
    end
  end
  task automatic push(input cw_t w, input string t);
    exp_q.push_back(w);
    tag_q.push_back(t);
  endtask
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic eq,
                     input int md_d, input logic dz, input int abort);
    build(op, fn, ovf, eq, md_d, dz);
    for (int k = 1; k <= seq_w.size(); k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        OPCODE = op; FUNCT = fn; overflow = ovf; EQ = eq; div_zero = dz;
      end
      md_done = (md_d != 0 && k == 5 + md_d);
      if (k == abort) begin
        reset = 1'b0; md_done = 1'b0;
        push(Z, "RST_MID");
        @(posedge clk); #1;
        push(Z, "RST_HOLD");
        @(posedge clk); #1;
        reset = 1'b1;
        push(cw(10'h008, 0, 0, 3, 7, 0, 0, 0, 0), "RESET");
        return;
      end
      push(seq_w[k-1], seq_t[k-1]);
    end
  endtask
  logic [11:0] legal [17] = '{12'h020, 12'h022, 12'h024, 12'h02a, 12'h008, 12'h010, 12'h012,
                              12'h018, 12'h01a, 12'h200, 12'h100, 12'h140, 12'h8c0, 12'hac0,
                              12'h3c0, 12'h080, 12'h0c0};
  initial begin
    repeat (3) begin
      @(posedge clk); #1;
      push(Z, "RST");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    push(cw(10'h008, 0, 0, 3, 7, 0, 0, 0, 0), "RESET");
    run(6'h00, 6'h20, 0, 0, 0, 0, 0);
    run(6'h00, 6'h20, 1, 0, 0, 0, 0);
    run(6'h00, 6'h22, 1, 0, 0, 0, 0);
    run(6'h08, 6'h15, 1, 0, 0, 0, 0);
    run(6'h08, 6'h15, 0, 0, 0, 0, 0);
    run(6'h00, 6'h24, 1, 0, 0, 0, 0);
    run(6'h00, 6'h2a, 1, 0, 0, 0, 0);
    run(6'h04, 6'h00, 0, 1, 0, 0, 0);
    run(6'h04, 6'h00, 0, 0, 0, 0, 0);
    run(6'h05, 6'h00, 0, 0, 0, 0, 0);
    run(6'h05, 6'h00, 0, 1, 0, 0, 0);
    run(6'h23, 6'h00, 0, 0, 0, 0, 0);
    run(6'h2b, 6'h00, 0, 0, 0, 0, 0);
    run(6'h0f, 6'h00, 0, 0, 0, 0, 0);
    run(6'h02, 6'h00, 0, 0, 0, 0, 0);
    run(6'h03, 6'h00, 0, 0, 0, 0, 0);
    run(6'h00, 6'h08, 0, 0, 0, 0, 0);
    run(6'h00, 6'h10, 0, 0, 0, 0, 0);
    run(6'h00, 6'h12, 0, 0, 0, 0, 0);
    run(6'h3f, 6'h00, 0, 0, 0, 0, 0);
    run(6'h00, 6'h3f, 0, 0, 0, 0, 0);
    run(6'h00, 6'h1a, 0, 0, 10, 1, 0);
    run(6'h00, 6'h1a, 0, 0, 0, 0, 0);
    run(6'h00, 6'h18, 0, 0, 40, 1, 0);
    run(6'h00, 6'h18, 0, 0, 1, 0, 0);
    run(6'h23, 6'h00, 0, 0, 0, 0, 6);
    run(6'h00, 6'h20, 0, 0, 0, 0, 5);
    for (int i = 0; i < 120; i++) begin
      logic [11:0] sel;
      logic [5:0] op, fn;
      int ab;
      sel = ($urandom_range(0, 19) < 17) ? legal[$urandom_range(0, 16)] : 12'($urandom);
      op = sel[11:6];
      fn = (op != 6'h00) ? 6'($urandom) : sel[5:0];
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 8)) : 0;
      run(op, fn, 1'($urandom), 1'($urandom), int'($urandom_range(0, 40)), 1'($urandom), ab);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
